// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 16x-oversampled UART receiver; even parity when UART_RX_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_receiver #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Rx_EN,
   input  logic                 RxD,
   input  logic                 Rx_sample_ENABLE,
   output logic [DATA_BITS-1:0] Rx_DATA,
   output logic                 Rx_VALID,
   output logic                 Rx_FERROR,
   output logic                 Rx_PERROR
);
   localparam int c_CNT_W = $clog2(OVERSAMPLE);
   localparam int c_IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [c_CNT_W-1:0] c_MID      = c_CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(OVERSAMPLE - 1);
   localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(DATA_BITS - 1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] c_PARITY = 3'd3;
`endif
   localparam logic [2:0] c_STOP   = 3'd4;

   logic                 r_rxd_meta, r_rxd_s;
   logic [2:0]           r_state, w_state_next;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_IDX_W-1:0]   r_idx;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 r_valid, r_ferr;
   logic                 w_mid_tick, w_bit_tick;
   logic                 w_start_det, w_start_ok, w_shift_en, w_stop_ok, w_stop_bad;
`ifdef UART_RX_PARITY_EN
   logic                 r_perr, r_perr_pend, w_par_chk;
`endif

   assign w_mid_tick = Rx_sample_ENABLE && (r_cnt == c_MID);
   assign w_bit_tick = Rx_sample_ENABLE && (r_cnt == c_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rxd_meta <= 1'b1;
         r_rxd_s    <= 1'b1;
         r_state    <= c_IDLE;
      end else begin
         r_rxd_meta <= RxD;
         r_rxd_s    <= r_rxd_meta;
         r_state    <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (!Rx_EN) begin
         w_state_next = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:   if (Rx_sample_ENABLE && !r_rxd_s) w_state_next = c_START;
            c_START:  if (w_mid_tick) w_state_next = r_rxd_s ? c_IDLE : c_DATA;
            c_DATA:   if (w_bit_tick && (r_idx == c_LAST_BIT))
`ifdef UART_RX_PARITY_EN
                         w_state_next = c_PARITY;
            c_PARITY: if (w_bit_tick) w_state_next = c_STOP;
`else
                         w_state_next = c_STOP;
`endif
            c_STOP:   if (w_bit_tick) w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
         endcase
      end
   end

   always_comb begin
      w_start_det = 1'b0;
      w_start_ok  = 1'b0;
      w_shift_en  = 1'b0;
      w_stop_ok   = 1'b0;
      w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_chk   = 1'b0;
`endif
      if (Rx_EN) begin
         case (r_state)
            c_IDLE:   w_start_det = Rx_sample_ENABLE && !r_rxd_s;
            c_START:  w_start_ok  = w_mid_tick && !r_rxd_s;
            c_DATA:   w_shift_en  = w_bit_tick;
`ifdef UART_RX_PARITY_EN
            c_PARITY: w_par_chk   = w_bit_tick;
`endif
            c_STOP: begin
               w_stop_ok  = w_bit_tick && r_rxd_s;
               w_stop_bad = w_bit_tick && !r_rxd_s;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr      <= 1'b0;
         r_perr_pend <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         // The counter only runs inside a frame so every start bit sees the same phase.
         if (!Rx_EN || w_start_det || w_start_ok)
            r_cnt <= '0;
         else if ((r_state != c_IDLE) && Rx_sample_ENABLE)
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
         if (w_start_ok)
            r_idx <= '0;
         else if (w_shift_en)
            r_idx <= r_idx + 1'b1;
         if (w_shift_en)
            r_shift <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
         if (w_start_det) begin
            r_ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr      <= 1'b0;
            r_perr_pend <= 1'b0;
`endif
         end
`ifdef UART_RX_PARITY_EN
         if (w_par_chk && (r_rxd_s != ^r_shift))
            r_perr_pend <= 1'b1;
`endif
         if (w_stop_ok) begin
            r_data <= r_shift;
`ifdef UART_RX_PARITY_EN
            if (r_perr_pend)
               r_perr  <= 1'b1;
            else
               r_valid <= 1'b1;
`else
            r_valid <= 1'b1;
`endif
         end
         if (w_stop_bad)
            r_ferr <= 1'b1;
      end
   end

   assign Rx_DATA   = r_data;
   assign Rx_VALID  = r_valid;
   assign Rx_FERROR = r_ferr;
`ifdef UART_RX_PARITY_EN
   assign Rx_PERROR = r_perr;
`else
   assign Rx_PERROR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// Scoreboard bench for uart_receiver: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_uart_receiver;
   localparam int BIT_CLKS = 64;   // tick every 4 clk, 16 ticks per bit

   logic       clk = 1'b0;
   logic       reset, Rx_EN, RxD, Rx_sample_ENABLE;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID, Rx_FERROR, Rx_PERROR;

   typedef struct packed {
      logic [2:0] flags;           // {valid, ferror, perror}
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   tick_div = 0;
   logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

   uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .Rx_EN            (Rx_EN),
      .RxD              (RxD),
      .Rx_sample_ENABLE (Rx_sample_ENABLE),
      .Rx_DATA          (Rx_DATA),
      .Rx_VALID         (Rx_VALID),
      .Rx_FERROR        (Rx_FERROR),
      .Rx_PERROR        (Rx_PERROR)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tick_div = (tick_div == 3) ? 0 : tick_div + 1;
      Rx_sample_ENABLE = (tick_div == 0);
   end

   // Monitor: any valid strobe or newly raised error flag is one DUT event.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_valid = 1'b0;
         prev_ferr  = 1'b0;
         prev_perr  = 1'b0;
      end else begin
         if (prev_valid) begin
            n_checks++;
            if (Rx_VALID) begin
               n_errors++;
               $display("FAIL valid_width: Rx_VALID still 1 on second cycle, required 0");
            end
         end
         if (Rx_VALID || (Rx_FERROR && !prev_ferr) || (Rx_PERROR && !prev_perr)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_event: flags=%b data=%h, required no event",
                        {Rx_VALID, Rx_FERROR, Rx_PERROR}, Rx_DATA);
            end else begin
               e = exp_q.pop_front();
               if ({Rx_VALID, Rx_FERROR, Rx_PERROR} != e.flags || Rx_DATA != e.data) begin
                  n_errors++;
                  $display("FAIL event: flags=%b data=%h, required flags=%b data=%h",
                           {Rx_VALID, Rx_FERROR, Rx_PERROR}, Rx_DATA, e.flags, e.data);
               end
            end
         end
         prev_valid = Rx_VALID;
         prev_ferr  = Rx_FERROR;
         prev_perr  = Rx_PERROR;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input logic [2:0] flags, input logic [7:0] data);
      exp_t e;
      e.flags = flags;
      e.data  = data;
      exp_q.push_back(e);
   endtask

   task automatic send_bit(input logic b);
      RxD = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par) $display("note: parity bit ignored in this build");
`endif
      send_bit(stop);
      RxD = 1'b1;
   endtask

   task automatic drain(input string name);
      int waited = 0;
      while (exp_q.size() != 0 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s_pending: %0d events outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      Rx_EN = 1'b1;
      RxD   = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_data",   Rx_DATA, 8'h00);
      check("reset_valid",  {7'd0, Rx_VALID},  8'h00);
      check("reset_ferror", {7'd0, Rx_FERROR}, 8'h00);
      check("reset_perror", {7'd0, Rx_PERROR}, 8'h00);
      repeat (BIT_CLKS) @(negedge clk);

      push(3'b100, 8'h55);
      send_frame(8'h55, 1'b0, 1'b1);
      drain("frame_55");

`ifdef UART_RX_PARITY_EN
      push(3'b100, 8'hA3);
      send_frame(8'hA3, 1'b0, 1'b1);
      push(3'b001, 8'hA3);
      send_frame(8'hA3, 1'b1, 1'b1);
      drain("parity");
      check("perror_sticky", {7'd0, Rx_PERROR}, 8'h01);
      check("perror_no_ferror", {7'd0, Rx_FERROR}, 8'h00);
`endif

      // Stop bit low: data must stay at the previous byte.
`ifdef UART_RX_PARITY_EN
      push(3'b010, 8'hA3);
`else
      push(3'b010, 8'h55);
`endif
      send_frame(8'h0F, 1'b0, 1'b0);
      drain("framing");

      // Four-tick low glitch is a start detection that fails its mid-bit check.
      RxD = 1'b0;
      repeat (16) @(negedge clk);
      RxD = 1'b1;
      drain("glitch");
      check("glitch_ferror", {7'd0, Rx_FERROR}, 8'h00);
      check("glitch_perror", {7'd0, Rx_PERROR}, 8'h00);

      push(3'b100, 8'h3C);
      send_frame(8'h3C, 1'b0, 1'b1);
      drain("frame_3c");

      push(3'b100, 8'h12);
      push(3'b100, 8'h34);
      send_frame(8'h12, 1'b0, 1'b1);
      send_frame(8'h34, 1'b1, 1'b1);
      drain("back_to_back");

      Rx_EN = 1'b0;
      send_frame(8'h00, 1'b0, 1'b1);
      repeat (BIT_CLKS) @(negedge clk);
      Rx_EN = 1'b1;
      drain("disabled");
      check("disabled_data",   Rx_DATA, 8'h34);
      check("disabled_ferror", {7'd0, Rx_FERROR}, 8'h00);

      fork
         send_frame(8'hFF, 1'b0, 1'b1);
         begin
            repeat (BIT_CLKS * 3 + 20) @(negedge clk);
            reset = 1'b1;
            repeat (3) @(negedge clk);
            reset = 1'b0;
         end
      join
      drain("reset_abort");
      check("abort_data",   Rx_DATA, 8'h00);
      check("abort_valid",  {7'd0, Rx_VALID},  8'h00);
      check("abort_ferror", {7'd0, Rx_FERROR}, 8'h00);
      check("abort_perror", {7'd0, Rx_PERROR}, 8'h00);

      push(3'b100, 8'h81);
      send_frame(8'h81, 1'b0, 1'b1);
      drain("frame_81");
      check("final_data", Rx_DATA, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

UART receive engine, the receive-side counterpart of the team's transmit path. Oversamples the serial line at 16× baud using the shared baud-rate tick, detects and validates the start bit, shifts in a data byte LSB first, optionally checks even parity, and checks the stop bit. Presents the byte with a one-cycle valid strobe and sticky error flags to the host-side logic.

## Interface
Parameters:
- DATA_BITS, 8, number of data bits per frame (5–8 supported).
- OVERSAMPLE, 16, Rx_sample_ENABLE ticks per bit period; must be even.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- Rx_EN  input  1  receiver enable; low forces IDLE and ignores the line.
- RxD  input  1  asynchronous serial line, idle high.
- Rx_sample_ENABLE  input  1  one-clk-wide pulse at OVERSAMPLE × baud from the baud generator.
- Rx_DATA  output  DATA_BITS  last received byte.
- Rx_VALID  output  1  one-clk pulse: Rx_DATA updated with a frame free of errors.
- Rx_FERROR  output  1  framing error (stop bit sampled low); sticky.
- Rx_PERROR  output  1  parity error; sticky.

## Operation
- RxD passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxd_s.
- Internal 4-bit tick counter (width log2(OVERSAMPLE)) increments only on Rx_sample_ENABLE; wraps OVERSAMPLE-1 → 0.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on Rx_sample_ENABLE with rxd_s == 0 and Rx_EN == 1 → START, counter ← 0, Rx_FERROR and Rx_PERROR cleared.
  - START: on tick with counter == OVERSAMPLE/2-1 (mid-bit): rxd_s == 0 → DATA, counter ← 0, bit index ← 0; rxd_s == 1 → IDLE (glitch rejected, no flags).
  - DATA: on tick with counter == OVERSAMPLE-1: shift rxd_s into shift register MSB, shifting right (LSB first on the line), bit index++; after DATA_BITS bits → PARITY (macro defined) or STOP.
  - PARITY: same sample point; compare rxd_s against even parity of received bits; mismatch latches perr_pending → STOP.
  - STOP: same sample point; rxd_s == 1 → Rx_DATA ← shift register, Rx_VALID = 1 if no parity error, else Rx_PERROR = 1; rxd_s == 0 → Rx_FERROR = 1, Rx_DATA unchanged, no Rx_VALID. Always → IDLE.
- Error flags remain set until the next start-bit detection or reset.
- Rx_EN deasserted in any state: next clk → IDLE, counter ← 0, partial frame discarded, outputs unchanged.
- Receiver returns to IDLE at stop-bit mid-point, so a back-to-back start bit is detected without loss.

## Timing
- Reset values: Rx_DATA = 0, Rx_VALID = 0, Rx_FERROR = 0, Rx_PERROR = 0, state IDLE, counter 0, synchronizer flops 1.
- reset has priority over Rx_EN and all ticks; a reset mid-frame aborts it with no strobe.
- Line-to-decision latency: 2 clk (synchronizer) plus up to one tick period for start detection.
- Rx_VALID / error flags assert on the clk edge where the stop-bit mid-sample tick is processed; Rx_VALID high exactly one clk cycle.
- Rx_DATA changes only in the same cycle Rx_VALID or a parity-error result is produced.
- Rx_sample_ENABLE held high continuously is legal (tick every clk); behaviour scales accordingly.

## Configuration
- UART_RX_PARITY_EN defined: frame = start + DATA_BITS + even parity + stop; PARITY state and Rx_PERROR logic present.
- Undefined: frame = start + DATA_BITS + stop; PARITY state absent, Rx_PERROR tied 0.

## Test plan
- Frame 0x55 at 16× ticks, no parity build: Rx_DATA = 0x55, Rx_VALID one-cycle pulse, both error flags 0.
- Parity build, 0xA3 with correct even parity (0) then 0xA3 with parity 1: first Rx_VALID pulse; second Rx_PERROR = 1, no Rx_VALID.
- Frame 0x0F with stop bit driven 0: Rx_FERROR = 1, Rx_VALID never asserts, Rx_DATA retains previous value; flag clears on next start bit.
- RxD low pulse of 4 ticks in IDLE: returns to IDLE, no Rx_VALID, no flags; following valid frame 0x3C received correctly.
- Back-to-back frames 0x12, 0x34 with no idle gap: two Rx_VALID pulses, data 0x12 then 0x34.
- reset asserted mid-DATA of frame 0xFF, then valid frame 0x81: no strobe for aborted frame, all outputs 0 after reset, then Rx_DATA = 0x81 with Rx_VALID.
